// File: rtl/mem_arbiter.sv
// Multi-channel memory arbiter: grants one requester at a time (fixed priority or
// round-robin) and moves 1/2/4-byte little-endian transfers over a byte-wide RAM port.
module mem_arbiter #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [31:0]           mem_a,
  output logic                  mem_wr,
  input  logic [NUM_CH-1:0]     ch_req,
  input  logic [NUM_CH-1:0]     ch_wr,
  input  logic [2*NUM_CH-1:0]   ch_len,
  input  logic [32*NUM_CH-1:0]  ch_addr,
  input  logic [32*NUM_CH-1:0]  ch_wdata,
  output logic [NUM_CH-1:0]     ch_ready,
  output logic [31:0]           result
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;

  logic [IDX_W-1:0] win, gnt, last_grant;
  logic             found;
  int unsigned      idx;
  logic             grant, step, done;
  logic             wr_q, mem_wr_q;
  logic [2:0]       len_dec, len_q, cnt;
  logic [31:0]      addr_q, result_q;
  logic [3:0][7:0]  wdata_q, rbuf, rmerge;

  logic [1:0]       len_a   [NUM_CH];
  logic [31:0]      addr_a  [NUM_CH];
  logic [31:0]      wdata_a [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign len_a[g]   = ch_len[2*g +: 2];
    assign addr_a[g]  = ch_addr[32*g +: 32];
    assign wdata_a[g] = ch_wdata[32*g +: 32];
  end

  // Winner search; round-robin starts just after the previous grant and wraps
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ARB_MODE == 1) idx = (32'(last_grant) + 32'd1 + i) % NUM_CH;
      else               idx = i;
      if (!found && ch_req[IDX_W'(idx)]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    case (len_a[win])
      2'd0:    len_dec = 3'd1;
      2'd1:    len_dec = 3'd2;
      default: len_dec = 3'd4;
    endcase
  end

  // Final read byte arrives in the done cycle, so it is merged in combinationally
  always_comb begin
    rmerge = rbuf;
    if (cnt != 3'd0) rmerge[2'(cnt - 3'd1)] = mem_din;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    step      = 1'b0;
    done      = (state == BUSY) && (cnt == len_q);
    if (rdy_in) begin
      case (state)
        IDLE: begin
          if (found) begin
            grant     = 1'b1;
            state_nxt = BUSY;
          end
        end
        BUSY: begin
          step = 1'b1;
          if (done) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operand latch at grant, then one byte per enabled edge
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      gnt        <= '0;
      last_grant <= IDX_W'(NUM_CH - 1);
      wr_q       <= 1'b0;
      len_q      <= 3'd0;
      cnt        <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= '0;
      rbuf       <= '0;
      result_q   <= 32'd0;
      mem_a      <= 32'd0;
      mem_dout   <= 8'd0;
      mem_wr_q   <= 1'b0;
    end else if (grant) begin
      gnt        <= win;
      last_grant <= win;
      wr_q       <= ch_wr[win];
      len_q      <= len_dec;
      cnt        <= 3'd0;
      addr_q     <= addr_a[win];
      wdata_q    <= wdata_a[win];
      rbuf       <= '0;
      mem_a      <= addr_a[win];
      mem_dout   <= wdata_a[win][7:0];
      mem_wr_q   <= ch_wr[win];
    end else if (step) begin
      if (done) begin
        if (!wr_q) result_q <= rmerge;
      end else begin
        cnt <= cnt + 3'd1;
        if (!wr_q) rbuf <= rmerge;
        if ((cnt + 3'd1) < len_q) begin
          mem_a    <= addr_q + 32'(cnt + 3'd1);
          mem_dout <= wdata_q[2'(cnt + 3'd1)];
        end else begin
          mem_wr_q <= 1'b0;
        end
      end
    end
  end

  assign mem_wr   = mem_wr_q & rdy_in;
  assign ch_ready = (done && rdy_in) ? (NUM_CH'(1) << gnt) : '0;
  assign result   = (done && !wr_q) ? rmerge : result_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a fixed-priority and a round-robin instance share
// the channel inputs; a byte RAM model answers the fixed-priority instance.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic [2:0]  ch_req = '0;
  logic [2:0]  ch_wr = '0;
  logic [5:0]  ch_len = '0;
  logic [95:0] ch_addr = '0;
  logic [95:0] ch_wdata = '0;

  logic [7:0]  mem_din_f, mem_dout_f;
  logic [31:0] mem_a_f, result_f;
  logic        mem_wr_f;
  logic [2:0]  ch_ready_f;

  logic [7:0]  mem_din_rr, mem_dout_rr;
  logic [31:0] mem_a_rr, result_rr;
  logic        mem_wr_rr;
  logic [2:0]  ch_ready_rr;

  logic [7:0]  wram [1024];
  int          wr_count = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          base;
  logic [31:0] exp_rdy;

  logic [31:0] st_a   [8];
  logic [7:0]  st_d   [8];
  logic        st_wr  [8];
  logic [2:0]  st_rdy [8];

  always #5 clk_in = ~clk_in;

  mem_arbiter #(.NUM_CH(3), .ARB_MODE(0)) u_fix (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din_f), .mem_dout(mem_dout_f), .mem_a(mem_a_f), .mem_wr(mem_wr_f),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_len(ch_len), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_ready(ch_ready_f), .result(result_f)
  );

  mem_arbiter #(.NUM_CH(3), .ARB_MODE(1)) u_rr (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din_rr), .mem_dout(mem_dout_rr), .mem_a(mem_a_rr), .mem_wr(mem_wr_rr),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_len(ch_len), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_ready(ch_ready_rr), .result(result_rr)
  );

  assign mem_din_rr = 8'h00;

  // Registered-read RAM: byte at address a reads back as {a[1:0]+1, a[1:0]+1}
  always @(posedge clk_in) begin
    mem_din_f <= {4'(mem_a_f[1:0]) + 4'd1, 4'(mem_a_f[1:0]) + 4'd1};
    if (mem_wr_f) begin
      wram[mem_a_f[9:0]] <= mem_dout_f;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    st_a   = '{32'h300, 32'h301, 32'h301, 32'h301, 32'h301, 32'h302, 32'h303, 32'h303};
    st_d   = '{8'h21, 8'h43, 8'h43, 8'h43, 8'h43, 8'h65, 8'h87, 8'h87};
    st_wr  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    st_rdy = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};

    step();
    step();
    check("rst_mem_a", mem_a_f, 32'h0);
    check("rst_mem_wr", 32'(mem_wr_f), 32'h0);
    check("rst_mem_dout", 32'(mem_dout_f), 32'h0);
    check("rst_result", result_f, 32'h0);
    check("rst_ready", 32'(ch_ready_f), 32'h0);
    rst_in = 1'b0;

    // ch0 word read at 0x100
    ch_addr[31:0] = 32'h100;
    ch_len[1:0]   = 2'd2;
    ch_req        = 3'b001;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c <= 4) begin
        check("rd_addr", mem_a_f, 32'h100 + 32'(c - 1));
        check("rd_wr", 32'(mem_wr_f), 32'h0);
      end
      check("rd_ready", 32'(ch_ready_f), (c == 5) ? 32'h1 : 32'h0);
    end
    check("rd_result", result_f, 32'h44332211);
    ch_req = 3'b000;
    step();
    check("rd_ready_off", 32'(ch_ready_f), 32'h0);
    check("rd_result_hold", result_f, 32'h44332211);

    // ch1 halfword write to 0x2000
    base           = wr_count;
    ch_addr[63:32] = 32'h2000;
    ch_wdata[63:32] = 32'hAABBCCDD;
    ch_len[3:2]    = 2'd1;
    ch_wr          = 3'b010;
    ch_req         = 3'b010;
    step();
    check("wr_c1_wr", 32'(mem_wr_f), 32'h1);
    check("wr_c1_addr", mem_a_f, 32'h2000);
    check("wr_c1_data", 32'(mem_dout_f), 32'hDD);
    step();
    check("wr_c2_wr", 32'(mem_wr_f), 32'h1);
    check("wr_c2_addr", mem_a_f, 32'h2001);
    check("wr_c2_data", 32'(mem_dout_f), 32'hCC);
    step();
    check("wr_c3_wr", 32'(mem_wr_f), 32'h0);
    check("wr_c3_ready", 32'(ch_ready_f), 32'h2);
    check("wr_result", result_f, 32'h44332211);
    ch_req = 3'b000;
    ch_wr  = 3'b000;
    step();
    check("wr_count", 32'(wr_count - base), 32'd2);
    check("wr_bytes", {16'h0, wram[1], wram[0]}, 32'h0000CCDD);

    // Fixed priority: ch0 keeps winning until it drops req
    ch_addr = {32'h102, 32'h101, 32'h100};
    ch_len  = 6'b000000;
    ch_req  = 3'b111;
    for (int c = 1; c <= 14; c++) begin
      step();
      case (c)
        2, 5, 8: exp_rdy = 32'h1;
        11:      exp_rdy = 32'h2;
        14:      exp_rdy = 32'h4;
        default: exp_rdy = 32'h0;
      endcase
      check("fp_ready", 32'(ch_ready_f), exp_rdy);
      if (c == 8)  ch_req[0] = 1'b0;
      if (c == 11) ch_req[1] = 1'b0;
      if (c == 14) ch_req[2] = 1'b0;
    end
    check("fp_result", result_f, 32'h00000033);
    step();

    // 4-byte write with rdy_in low for three cycles during byte 1
    base            = wr_count;
    ch_addr[31:0]   = 32'h300;
    ch_wdata[31:0]  = 32'h87654321;
    ch_len[1:0]     = 2'd2;
    ch_wr           = 3'b001;
    ch_req          = 3'b001;
    for (int c = 1; c <= 8; c++) begin
      step();
      rdy_in = !(c >= 2 && c <= 4);
      #1;
      check("st_wr", 32'(mem_wr_f), 32'(st_wr[c-1]));
      check("st_addr", mem_a_f, st_a[c-1]);
      check("st_data", 32'(mem_dout_f), 32'(st_d[c-1]));
      check("st_ready", 32'(ch_ready_f), 32'(st_rdy[c-1]));
    end
    ch_req = 3'b000;
    ch_wr  = 3'b000;
    step();
    check("st_count", 32'(wr_count - base), 32'd4);
    check("st_bytes", {wram[10'h303], wram[10'h302], wram[10'h301], wram[10'h300]}, 32'h87654321);

    // Reset in cycle 2 of a 4-byte read on ch2
    ch_addr[95:64] = 32'h100;
    ch_len[5:4]    = 2'd2;
    ch_req         = 3'b100;
    step();
    step();
    check("rr_pre_addr", mem_a_f, 32'h101);
    rst_in = 1'b1;
    ch_req = 3'b000;
    #1;
    check("mr_mem_a", mem_a_f, 32'h0);
    check("mr_mem_wr", 32'(mem_wr_f), 32'h0);
    check("mr_result", result_f, 32'h0);
    check("mr_ready", 32'(ch_ready_f), 32'h0);
    step();
    rst_in = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      check("mr_no_pulse", 32'(ch_ready_f), 32'h0);
    end
    ch_addr[63:32] = 32'h103;
    ch_len[3:2]    = 2'd0;
    ch_req         = 3'b010;
    step();
    step();
    check("mr_next_ready", 32'(ch_ready_f), 32'h2);
    check("mr_next_result", result_f, 32'h00000044);
    ch_req = 3'b000;
    step();

    // Round-robin instance from a clean reset
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    ch_len = 6'b000000;
    ch_req = 3'b111;
    for (int c = 1; c <= 11; c++) begin
      step();
      case (c)
        2:       exp_rdy = 32'h1;
        5:       exp_rdy = 32'h2;
        8:       exp_rdy = 32'h4;
        11:      exp_rdy = 32'h1;
        default: exp_rdy = 32'h0;
      endcase
      check("rr_ready", 32'(ch_ready_rr), exp_rdy);
    end
    ch_req = 3'b000;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
